torpedo_pool_ctrl: RTL
======================

# torpedo_pool_ctrl

Parametrised torpedo allocator and lifetime manager for the Asteroids top level. It replaces the cascaded fire chain between torpedo instances with one central controller. The controller debounces the fire button on frame boundaries and supports single-shot or auto-fire. It allocates the lowest free torpedo slot, enforces a refire cooldown, and retires slots on hit, off-screen or lifetime expiry. Its `launch`/`active` vectors drive the per-slot Torpedo_Unit instances directly.

## Interface
Parameters:
- `T_NUM`, 4: number of torpedo slots (1..16).
- `LIFE_FRAMES`, 60: frames a torpedo flies before auto-retire (1..255).
- `COOLDOWN_FRAMES`, 8: minimum frames between consecutive launches (0..255).
- `DEB_FRAMES`, 2: consecutive frames fire must read high to count as a press (1..15).
- `AUTO_FIRE`, 0: 0 = one shot per press; 1 = repeat shots while held.

Ports:
- `clk` in 1: system clock (clk_25 domain).
- `reset` in 1: synchronous, active-high.
- `vsync_pulse` in 1: one-cycle frame tick.
- `fire` in 1: raw fire button level.
- `enable` in 1: 0 blocks new requests/launches (game over, opening screen); flying torpedoes continue.
- `hit` in T_NUM: per-slot retire request (torpedo struck asteroid).
- `offscreen` in T_NUM: per-slot retire request.
- `launch` out T_NUM: one-cycle pulse; slot i must latch ship position/heading.
- `active` out T_NUM: slot i is flying.
- `active_cnt` out $clog2(T_NUM+1): popcount of `active`.
- `dropped` out 1: one-cycle pulse when a request is discarded because the pool is full.

## Operation
- Fire FSM, evaluated only on `vsync_pulse` cycles, has 3 states: REL, DEB, HELD.
  - REL: fire=1 -> DEB with deb_cnt=1, or straight to HELD plus request if DEB_FRAMES=1.
  - DEB: fire=1 increments deb_cnt; reaching DEB_FRAMES -> HELD and raises a request. fire=0 -> REL.
  - HELD: fire=0 -> REL. With AUTO_FIRE=1 and fire=1, a new request is raised on every frame where cooldown is 0 and no request is pending.
- Request is a single `pend` bit. Re-requests while `pend`=1 merge into it (no queueing).
- Launch condition: `pend` & `enable` & cooldown==0 & free slot exists. When met, launch goes to the lowest-index slot with active=0. That slot's life counter loads LIFE_FRAMES, cooldown loads COOLDOWN_FRAMES, and `pend` clears.
- If `pend` & `enable` & cooldown==0 & all slots active: `dropped` pulses and `pend` clears.
- If `pend` & cooldown>0: `pend` holds.
- If `enable`=0: `pend` is cleared and the fire FSM is forced to REL.
- Per-slot FSM has 2 states: IDLE, FLY.
  - FLY decrements its life counter on each `vsync_pulse`.
  - Retire (-> IDLE) when the counter reaches 0, or when `hit[i]` or `offscreen[i]` is set on any cycle.
  - `hit`/`offscreen` on an IDLE slot are ignored.
- Simultaneous events:
  - Retire of slot i and allocation in the same cycle: the allocator sees the pre-retire `active`, so slot i is not reused that cycle.
  - Cooldown decrement and a new launch in the same cycle: the load wins.
  - Life counter reaching 0 and `hit` in the same cycle: a single retire.
- Arithmetic: life and cooldown counters are 8 bit, deb_cnt is 4 bit, and all saturate at 0. `active_cnt` is a combinational popcount of registered `active`.

## Timing
- Reset: `launch`=0, `active`=0, `active_cnt`=0, `dropped`=0, `pend`=0, cooldown=0, all life counters 0, fire FSM=REL.
- Latency: `pend` is set at the edge ending the vsync cycle that completes debounce. `launch` and `active` rise together on the next cycle when the launch condition holds. Press-to-launch is DEB_FRAMES frames plus 1 clk.
- `launch` is exactly one cycle wide. `active[i]` is high from the launch cycle until the edge after the retire condition.
- Reset asserted mid-flight returns everything to the reset state on the next edge. No launch pulse is emitted in the reset cycle.

## Structure
- Shared package `asteroids_pkg`: fire FSM enum `fire_st_t {REL, DEB, HELD}` and slot enum `slot_st_t {IDLE, FLY}`.
- Lowest-free-slot priority encoder goes in a sub-module `prio_enc #(N)`, outputting a one-hot grant plus a `found` flag. It is reusable by the asteroid spawner.
- Per-slot life counters live in a generate loop inside this module.

## Test plan
- Single shot: T_NUM=4, DEB_FRAMES=2, AUTO_FIRE=0; hold fire 10 frames -> exactly one `launch`=4'b0001, 2 frames + 1 clk after the first high sample. `active_cnt`=1.
- Lifetime: LIFE_FRAMES=5, no hits -> `active[0]` drops after the 5th subsequent `vsync_pulse`. `active_cnt` returns to 0.
- Pool full: COOLDOWN_FRAMES=0, four presses -> launches 0001, 0010, 0100, 1000. Fifth press -> `dropped` pulses once, no launch.
- Auto-fire with cooldown: AUTO_FIRE=1, COOLDOWN_FRAMES=3, fire held 12 frames -> launches exactly 4 frames apart.
- Hit and reuse: hit[1] while slots 0–2 are active, with a request pending in the same cycle -> slot 3 is launched. The next request is launched into slot 1.
- Enable and reset: `enable`=0 during a press -> no launch and `pend`=0. `reset` asserted with 3 slots active -> all outputs 0 on the next edge.

Source files
------------

// File: rtl/asteroids_pkg.sv
// Shared types for the Asteroids top level: fire-button and torpedo-slot state encodings.
package asteroids_pkg;

  typedef enum logic [1:0] {REL, DEB, HELD} fire_st_t;
  typedef enum logic {IDLE, FLY} slot_st_t;

  localparam int unsigned CntW = 8;
  localparam int unsigned DebW = 4;

endpackage

// File: rtl/prio_enc.sv
// Lowest-index priority encoder: one-hot grant of the lowest set request bit.
module prio_enc #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0] req,
  output logic [N-1:0] grant,
  output logic         found
);

  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (req[i] && !found) begin
        grant[i] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/torpedo_pool_ctrl.sv
// Central torpedo allocator: debounced fire, single/auto shot, lowest-free-slot launch,
// refire cooldown and per-slot lifetime / hit / off-screen retirement.
module torpedo_pool_ctrl
  import asteroids_pkg::*;
#(
  parameter int unsigned T_NUM           = 4,
  parameter int unsigned LIFE_FRAMES     = 60,
  parameter int unsigned COOLDOWN_FRAMES = 8,
  parameter int unsigned DEB_FRAMES      = 2,
  parameter bit          AUTO_FIRE       = 1'b0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         vsync_pulse,
  input  logic                         fire,
  input  logic                         enable,
  input  logic [T_NUM-1:0]             hit,
  input  logic [T_NUM-1:0]             offscreen,
  output logic [T_NUM-1:0]             launch,
  output logic [T_NUM-1:0]             active,
  output logic [$clog2(T_NUM+1)-1:0]   active_cnt,
  output logic                         dropped
);

  localparam int unsigned         CntOutW    = $clog2(T_NUM + 1);
  localparam logic [DebW-1:0]     DebTarget  = DebW'(DEB_FRAMES);
  localparam logic [CntW-1:0]     LifeLoad   = CntW'(LIFE_FRAMES);
  localparam logic [CntW-1:0]     CoolLoad   = CntW'(COOLDOWN_FRAMES);

  fire_st_t          fire_st_q, fire_st_d;
  logic [DebW-1:0]   deb_cnt_q, deb_cnt_d, deb_inc;
  logic              pend_q, pend_d;
  logic [CntW-1:0]   cool_q, cool_d;
  logic              req;
  logic [T_NUM-1:0]  grant;
  logic              found;
  logic              serve, do_launch, do_drop;

  // Allocation looks at the registered active vector, so a slot retiring this cycle
  // is not handed out again until the next one.
  prio_enc #(
    .N (T_NUM)
  ) u_prio_enc (
    .req   (~active),
    .grant (grant),
    .found (found)
  );

  assign serve     = pend_q && enable && (cool_q == '0);
  assign do_launch = serve && found;
  assign do_drop   = serve && !found;
  assign deb_inc   = (deb_cnt_q == '1) ? deb_cnt_q : deb_cnt_q + 1'b1;

  always_comb begin
    fire_st_d = fire_st_q;
    deb_cnt_d = deb_cnt_q;
    req       = 1'b0;
    if (vsync_pulse) begin
      unique case (fire_st_q)
        REL: begin
          if (fire) begin
            if (DEB_FRAMES == 1) begin
              fire_st_d = HELD;
              req       = 1'b1;
            end else begin
              fire_st_d = DEB;
            end
            deb_cnt_d = DebW'(1);
          end
        end
        DEB: begin
          if (fire) begin
            deb_cnt_d = deb_inc;
            if (deb_inc >= DebTarget) begin
              fire_st_d = HELD;
              req       = 1'b1;
            end
          end else begin
            fire_st_d = REL;
            deb_cnt_d = '0;
          end
        end
        HELD: begin
          if (!fire) begin
            fire_st_d = REL;
            deb_cnt_d = '0;
          end else if (AUTO_FIRE && (cool_q == '0) && !pend_q) begin
            req = 1'b1;
          end
        end
        default: begin
          fire_st_d = REL;
          deb_cnt_d = '0;
        end
      endcase
    end
    if (!enable) begin
      fire_st_d = REL;
      deb_cnt_d = '0;
      req       = 1'b0;
    end
  end

  // A request arriving as the previous one is served starts a fresh request.
  always_comb begin
    pend_d = pend_q;
    if (serve)   pend_d = 1'b0;
    if (req)     pend_d = 1'b1;
    if (!enable) pend_d = 1'b0;
  end

  always_comb begin
    cool_d = cool_q;
    if (do_launch) begin
      cool_d = CoolLoad;
    end else if (vsync_pulse && (cool_q != '0)) begin
      cool_d = cool_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fire_st_q <= REL;
      deb_cnt_q <= '0;
      pend_q    <= 1'b0;
      cool_q    <= '0;
      launch    <= '0;
      dropped   <= 1'b0;
    end else begin
      fire_st_q <= fire_st_d;
      deb_cnt_q <= deb_cnt_d;
      pend_q    <= pend_d;
      cool_q    <= cool_d;
      launch    <= do_launch ? grant : '0;
      dropped   <= do_drop;
    end
  end

  for (genvar i = 0; i < T_NUM; i++) begin : g_slot
    slot_st_t        st_q, st_d;
    logic [CntW-1:0] life_q, life_d;

    always_comb begin
      st_d   = st_q;
      life_d = life_q;
      unique case (st_q)
        IDLE: begin
          if (do_launch && grant[i]) begin
            st_d   = FLY;
            life_d = LifeLoad;
          end
        end
        FLY: begin
          if (vsync_pulse && (life_q != '0)) life_d = life_q - 1'b1;
          // The last frame tick and a hit in the same cycle collapse into one retire.
          if (hit[i] || offscreen[i] || (vsync_pulse && (life_q <= CntW'(1)))) begin
            st_d   = IDLE;
            life_d = '0;
          end
        end
      endcase
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        st_q   <= IDLE;
        life_q <= '0;
      end else begin
        st_q   <= st_d;
        life_q <= life_d;
      end
    end

    assign active[i] = (st_q == FLY);
  end

  always_comb begin
    active_cnt = '0;
    for (int i = 0; i < T_NUM; i++) begin
      active_cnt = active_cnt + CntOutW'(active[i]);
    end
  end

endmodule
